// File: rtl/latency_ram.sv
// latency_ram: word-organised behavioural RAM that answers each request
// from the memory controller after LAT wait cycles. Progress is reported
// on ramstate (FREE/BUSY/ACCESS/ERROR) and read data is returned on ramload.
// The controller ungates the cache waits only while ramstate is ACCESS, so
// the timing of this block is the memory latency seen by the processor.
//
// Optional feature: define LATENCY_RAM_BOUNDS_CHECK_EN to flag word indices
// at or beyond DEPTH with ERROR (no write, ramload forced to 32'hBAD1BAD1).
// Without it the upper address bits are ignored and addresses wrap.

package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

module latency_ram
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LAT);

  typedef enum logic [1:0] { IDLE, WAIT, ACC } state_t;
  typedef enum logic { OP_READ, OP_WRITE } op_t;

  word_t mem [DEPTH] = '{default: 32'h0};

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  op_t           lat_op_q, lat_op_d;
  logic          acc_q, acc_d;
  word_t         load_q;
  logic          fresh_q;

  logic          req;
  op_t           op;
  logic [AW-1:0] idx;
  logic          same;
  logic          oob;
  logic          start;
  logic          rd_fire;
  logic          wr_en;
  logic          unused_addr;

  assign req  = ramREN | ramWEN;
  assign op   = ramWEN ? OP_WRITE : OP_READ;
  assign idx  = ramaddr[AW+1:2];
  assign same = req && (op == lat_op_q) && (idx == lat_addr_q);

`ifdef LATENCY_RAM_BOUNDS_CHECK_EN
  assign oob         = req && ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
  assign unused_addr = ^ramaddr[1:0];
  assign ramload     = (ramstate == ERROR) ? 32'hBAD1BAD1 : load_q;
`else
  assign oob         = 1'b0;
  assign unused_addr = ^{ramaddr[31:AW+2], ramaddr[1:0]};
  assign ramload     = load_q;
`endif

  // Next-state and status decode; any change of {op, index} while a
  // transaction is in flight drops it and treats the input as fresh from IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_op_d   = lat_op_q;
    acc_d      = 1'b0;
    ramstate   = FREE;
    start      = 1'b0;
    rd_fire    = 1'b0;
    wr_en      = 1'b0;

    if (fresh_q) begin
      state_d  = IDLE;
      ramstate = FREE;
    end else begin
      case (state_q)
        IDLE: begin
          start = 1'b1;
        end
        WAIT: begin
          if (same) begin
            ramstate = BUSY;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_d == LAT4) begin
              acc_d   = 1'b1;
              state_d = ACC;
              rd_fire = (lat_op_q == OP_READ);
            end
          end else begin
            start = 1'b1;
          end
        end
        ACC: begin
          if (same && acc_q) begin
            ramstate = ACCESS;
            wr_en    = (lat_op_q == OP_WRITE);
            state_d  = IDLE;
          end else begin
            start = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (start) begin
        if (oob) begin
          ramstate = ERROR;
          state_d  = IDLE;
        end else if (req) begin
          ramstate   = BUSY;
          lat_addr_d = idx;
          lat_op_d   = op;
          cnt_d      = 4'd1;
          if (LAT4 == 4'd1) begin
            acc_d   = 1'b1;
            state_d = ACC;
            rd_fire = (op == OP_READ);
          end else begin
            state_d = WAIT;
          end
        end else begin
          ramstate = FREE;
          state_d  = IDLE;
        end
      end
    end
  end

  // Control registers and read-data register; reset drops any transaction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      acc_q      <= 1'b0;
      load_q     <= 32'h0;
      fresh_q    <= 1'b1;
      lat_addr_q <= '0;
      lat_op_q   <= OP_READ;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      fresh_q    <= 1'b0;
      lat_addr_q <= lat_addr_d;
      lat_op_q   <= lat_op_d;
      if (rd_fire) begin
        load_q <= mem[idx];
      end
    end
  end

  // Write commit at the end of a held ACCESS cycle; reset cancels it.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem[lat_addr_q] <= ramstore;
    end
  end

endmodule

// File: tb/tb_latency_ram.sv
// tb_latency_ram: directed bench for latency_ram with a response scoreboard.
// Two instances are used: LAT=2 for the main scenarios and LAT=3 for the
// continuously held read. Expected ACCESS/ERROR responses are queued when a
// request is issued and popped by per-instance monitors.

module tb_latency_ram;
  import cpu_types_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  typedef struct {
    int        cycle;
    ramstate_t st;
    word_t     load;
    bit        chkLoad;
  } exp_t;

  logic      CLK;
  logic      RST;
  logic      renA, wenA, renB, wenB;
  word_t     addrA, dataA, addrB, dataB;
  word_t     loadA, loadB;
  ramstate_t stA, stB;

  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t qA[$];
  exp_t qB[$];

  latency_ram #(.LAT(LAT_A), .DEPTH(1024)) dutA (
    .CLK(CLK), .RST(RST), .ramREN(renA), .ramWEN(wenA),
    .ramaddr(addrA), .ramstore(dataA), .ramload(loadA), .ramstate(stA)
  );

  latency_ram #(.LAT(LAT_B), .DEPTH(1024)) dutB (
    .CLK(CLK), .RST(RST), .ramREN(renB), .ramWEN(wenB),
    .ramaddr(addrB), .ramstore(dataB), .ramload(loadB), .ramstate(stB)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Cycle counter used to timestamp expected responses
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int latOf(input int inst);
    return (inst == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic applyStimulus(input int inst, input logic ren, input logic wen,
                               input word_t addr, input word_t data, input logic rst);
    @(posedge CLK);
    #1;
    RST = rst;
    if (inst == 0) begin
      renA = ren; wenA = wen; addrA = addr; dataA = data;
    end else begin
      renB = ren; wenB = wen; addrB = addr; dataB = data;
    end
  endtask

  task automatic checkOutput(input string name, input int inst, input ramstate_t expSt,
                             input word_t expLd, input bit chkLd);
    ramstate_t st;
    word_t     ld;
    @(negedge CLK);
    st = (inst == 0) ? stA : stB;
    ld = (inst == 0) ? loadA : loadB;
    compared++;
    if (st != expSt || (chkLd && ld != expLd)) begin
      mismatched++;
      $display("[TB] FAIL %s: cycle %0d ramstate %0d ramload %h, expected ramstate %0d ramload %h",
               name, cyc, st, ld, expSt, expLd);
    end
  endtask

  task automatic expectResp(input int inst, input int cycle, input ramstate_t st,
                            input word_t load, input bit chk);
    exp_t e;
    e.cycle = cycle; e.st = st; e.load = load; e.chkLoad = chk;
    if (inst == 0) qA.push_back(e);
    else qB.push_back(e);
  endtask

  task automatic scoreEntry(input string tag, input exp_t e, input ramstate_t st, input word_t ld);
    compared++;
    if (cyc != e.cycle || st != e.st || (e.chkLoad && ld != e.load)) begin
      mismatched++;
      $display("[TB] FAIL %s: cycle %0d ramstate %0d ramload %h, expected cycle %0d ramstate %0d ramload %h",
               tag, cyc, st, ld, e.cycle, e.st, e.load);
    end
  endtask

  task automatic doWrite(input int inst, input word_t addr, input word_t data);
    int L;
    L = latOf(inst);
    applyStimulus(inst, 1'b0, 1'b1, addr, data, 1'b0);
    expectResp(inst, cyc + L, ACCESS, 32'h0, 1'b0);
    checkOutput("wr_busy", inst, BUSY, 32'h0, 1'b0);
    for (int k = 1; k < L; k++) begin
      applyStimulus(inst, 1'b0, 1'b1, addr, data, 1'b0);
      checkOutput("wr_busy", inst, BUSY, 32'h0, 1'b0);
    end
    applyStimulus(inst, 1'b0, 1'b1, addr, data, 1'b0);
    checkOutput("wr_access", inst, ACCESS, 32'h0, 1'b0);
    applyStimulus(inst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("wr_free", inst, FREE, 32'h0, 1'b0);
  endtask

  task automatic doRead(input int inst, input word_t addr, input word_t expData);
    int L;
    L = latOf(inst);
    applyStimulus(inst, 1'b1, 1'b0, addr, 32'h0, 1'b0);
    expectResp(inst, cyc + L, ACCESS, expData, 1'b1);
    checkOutput("rd_busy", inst, BUSY, 32'h0, 1'b0);
    for (int k = 1; k < L; k++) begin
      applyStimulus(inst, 1'b1, 1'b0, addr, 32'h0, 1'b0);
      checkOutput("rd_busy", inst, BUSY, 32'h0, 1'b0);
    end
    applyStimulus(inst, 1'b1, 1'b0, addr, 32'h0, 1'b0);
    checkOutput("rd_access", inst, ACCESS, expData, 1'b1);
    applyStimulus(inst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rd_free_hold", inst, FREE, expData, 1'b1);
  endtask

  // Monitor for instance A: every ACCESS/ERROR cycle consumes one expectation
  always @(negedge CLK) begin : monA
    exp_t e;
    if (stA == ACCESS || stA == ERROR) begin
      if (qA.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL A_unexpected: cycle %0d ramstate %0d, expected no response", cyc, stA);
      end else begin
        e = qA.pop_front();
        scoreEntry("A_resp", e, stA, loadA);
      end
    end
  end

  // Monitor for instance B: every ACCESS/ERROR cycle consumes one expectation
  always @(negedge CLK) begin : monB
    exp_t e;
    if (stB == ACCESS || stB == ERROR) begin
      if (qB.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL B_unexpected: cycle %0d ramstate %0d, expected no response", cyc, stB);
      end else begin
        e = qB.pop_front();
        scoreEntry("B_resp", e, stB, loadB);
      end
    end
  end

  // Directed scenario sequence
  initial begin : stim
    exp_t e;
    CLK = 1'b0;
    RST = 1'b1;
    renA = 1'b0; wenA = 1'b0; addrA = 32'h0; dataA = 32'h0;
    renB = 1'b0; wenB = 1'b0; addrB = 32'h0; dataB = 32'h0;
    repeat (3) @(posedge CLK);

    $display("[TB] reset and idle");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("reset_idle_A", 0, FREE, 32'h0, 1'b1);
    end
    checkOutput("reset_idle_B", 1, FREE, 32'h0, 1'b1);

    $display("[TB] write then read 0x40");
    doWrite(0, 32'h40, 32'hDEADBEEF);
    doRead(0, 32'h40, 32'hDEADBEEF);

    doWrite(0, 32'h44, 32'h44444444);
    doWrite(0, 32'h48, 32'h48484848);
    doWrite(0, 32'h4C, 32'h4C4C4C4C);
    doWrite(0, 32'h0,  32'h0A0A0A0A);
    doWrite(0, 32'hFFC, 32'h0FFC0FFC);

    $display("[TB] address change abandons read");
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    checkOutput("abn_busy0", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    expectResp(0, cyc + LAT_A, ACCESS, 32'h44444444, 1'b1);
    checkOutput("abn_busy1", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    checkOutput("abn_busy2", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    checkOutput("abn_access", 0, ACCESS, 32'h44444444, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("abn_free", 0, FREE, 32'h44444444, 1'b1);

    $display("[TB] WEN raised in ACCESS cycle");
    applyStimulus(0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
    checkOutput("wen_busy0", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
    checkOutput("wen_busy1", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h48, 32'hBADBAD00, 1'b0);
    checkOutput("wen_abandon", 0, BUSY, 32'h48484848, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("wen_free", 0, FREE, 32'h0, 1'b0);
    doRead(0, 32'h48, 32'h48484848);

    $display("[TB] reset during write ACCESS");
    applyStimulus(0, 1'b0, 1'b1, 32'h4C, 32'hCAFEF00D, 1'b0);
    expectResp(0, cyc + LAT_A, ACCESS, 32'h0, 1'b0);
    checkOutput("rst_busy0", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h4C, 32'hCAFEF00D, 1'b0);
    checkOutput("rst_busy1", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h4C, 32'hCAFEF00D, 1'b1);
    checkOutput("rst_access", 0, ACCESS, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0);
    checkOutput("rst_free", 0, FREE, 32'h0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0);
    expectResp(0, cyc + LAT_A, ACCESS, 32'h4C4C4C4C, 1'b1);
    checkOutput("rst_rd_busy0", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0);
    checkOutput("rst_rd_busy1", 0, BUSY, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0);
    checkOutput("rst_rd_access", 0, ACCESS, 32'h4C4C4C4C, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rst_rd_free", 0, FREE, 32'h4C4C4C4C, 1'b1);

    $display("[TB] address beyond DEPTH");
`ifdef LATENCY_RAM_BOUNDS_CHECK_EN
    applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    expectResp(0, cyc, ERROR, 32'hBAD1BAD1, 1'b1);
    checkOutput("oob_err0", 0, ERROR, 32'hBAD1BAD1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 1'b0);
    expectResp(0, cyc, ERROR, 32'hBAD1BAD1, 1'b1);
    checkOutput("oob_err1", 0, ERROR, 32'hBAD1BAD1, 1'b1);
    applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'h55555555, 1'b0);
    expectResp(0, cyc, ERROR, 32'hBAD1BAD1, 1'b1);
    checkOutput("oob_err_wr", 0, ERROR, 32'hBAD1BAD1, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("oob_free", 0, FREE, 32'h0, 1'b0);
    doRead(0, 32'h0, 32'h0A0A0A0A);
`else
    doRead(0, 32'h1000, 32'h0A0A0A0A);
    doWrite(0, 32'h1004, 32'h11111111);
    doRead(0, 32'h4, 32'h11111111);
`endif
    doRead(0, 32'hFFC, 32'h0FFC0FFC);

    $display("[TB] held read with LAT=3");
    doWrite(1, 32'h0, 32'hB0B0B0B0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    expectResp(1, cyc + 3,  ACCESS, 32'hB0B0B0B0, 1'b1);
    expectResp(1, cyc + 7,  ACCESS, 32'hB0B0B0B0, 1'b1);
    expectResp(1, cyc + 11, ACCESS, 32'hB0B0B0B0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k != 0) applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("hold_read", 1, ramstate_t'((k % 4 == 3) ? ACCESS : BUSY),
                  32'hB0B0B0B0, (k % 4 == 3));
    end
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("hold_free", 1, FREE, 32'hB0B0B0B0, 1'b1);

    repeat (4) @(posedge CLK);
    while (qA.size() != 0) begin
      e = qA.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL A_missing: no response seen, expected ramstate %0d at cycle %0d", e.st, e.cycle);
    end
    while (qB.size() != 0) begin
      e = qB.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL B_missing: no response seen, expected ramstate %0d at cycle %0d", e.st, e.cycle);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
